// File: rtl/cursor_capture.sv
// Captures res_in on each rising edge of right_cursor into a small show-ahead FIFO
// and presents the bytes on a valid/ready interface; a sticky flag records any dropped bytes.
module cursor_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         res_in,
  input  logic                     right_cursor,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             cursor_q, cursor_d;

  logic cap, pop, full, wr, drop;

  always_comb begin
    cap  = right_cursor & ~cursor_q;
    pop  = (count_q != '0) & out_ready;
    full = (count_q == CNT_W'(DEPTH));
    // When full, a same-cycle pop frees the slot the new byte lands in.
    wr   = cap & (~full | pop);
    drop = cap & full & ~pop;

    cursor_d = right_cursor;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr) begin
      mem_d[wr_ptr_q] = res_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cursor_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cursor_q   <= cursor_d;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cursor_capture.sv
// Directed, table-driven bench for cursor_capture: each record is one clock of
// inputs plus the outputs expected just after that clock edge.
module tb_cursor_capture;

  logic       clk;
  logic       rst;
  logic [7:0] res_in;
  logic       right_cursor;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       cur;
    logic [7:0] res;
    logic       rdy;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  cursor_capture #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .res_in(res_in),
    .right_cursor(right_cursor),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addv(input logic r, input logic c, input logic [7:0] d, input logic rdy,
                      input logic clr, input logic ev, input logic [7:0] ed,
                      input logic [2:0] ec, input logic eo);
    vec_t v;
    v.rst = r; v.cur = c; v.res = d; v.rdy = rdy; v.clr = clr;
    v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_ovf = eo;
    vecs.push_back(v);
  endtask

  // One strobe cycle followed by one idle cycle, no reads.
  task automatic addPulse(input logic [7:0] b, input logic [7:0] head,
                          input logic [2:0] c, input logic o);
    addv(0, 1, b, 0, 0, 1, head, c, o);
    addv(0, 0, 8'h00, 0, 0, 1, head, c, o);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    right_cursor = v.cur;
    res_in       = v.res;
    out_ready    = v.rdy;
    ovf_clr      = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input int step, input logic [7:0] act,
                          input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int step);
    checkOne("out_valid", step, {7'd0, out_valid}, {7'd0, v.exp_valid});
    checkOne("out_data",  step, out_data, v.exp_data);
    checkOne("count",     step, {5'd0, count}, {5'd0, v.exp_count});
    checkOne("overflow",  step, {7'd0, overflow}, {7'd0, v.exp_ovf});
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; right_cursor = 1'b0; res_in = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;

    // Reset then a single one-cycle capture held without reads
    addv(1, 0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 0);
    addv(0, 0, 8'hFF, 0, 0, 0, 8'h00, 3'd0, 0);
    addv(0, 1, 8'hA5, 0, 0, 1, 8'hA5, 3'd1, 0);
    addv(0, 0, 8'h3C, 0, 0, 1, 8'hA5, 3'd1, 0);
    addv(0, 0, 8'h00, 0, 0, 1, 8'hA5, 3'd1, 0);
    addv(0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0);

    // Long strobe captures only the first byte
    addv(0, 1, 8'h11, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 1, 8'h22, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 1, 8'h33, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 1, 8'h44, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 1, 8'h55, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 0, 8'h66, 0, 0, 1, 8'h11, 3'd1, 0);
    addv(0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0);

    // Fill, overflow on the fifth pulse, drain in order, then clear
    addPulse(8'h01, 8'h01, 3'd1, 0);
    addPulse(8'h02, 8'h01, 3'd2, 0);
    addPulse(8'h03, 8'h01, 3'd3, 0);
    addPulse(8'h04, 8'h01, 3'd4, 0);
    addPulse(8'h05, 8'h01, 3'd4, 1);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h02, 3'd3, 1);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h03, 3'd2, 1);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h04, 3'd1, 1);
    addv(0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 1);
    addv(0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 0);

    // Full FIFO with capture and pop in the same cycle
    addPulse(8'h01, 8'h01, 3'd1, 0);
    addPulse(8'h02, 8'h01, 3'd2, 0);
    addPulse(8'h03, 8'h01, 3'd3, 0);
    addPulse(8'h04, 8'h01, 3'd4, 0);
    addv(0, 1, 8'h05, 1, 0, 1, 8'h02, 3'd4, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h03, 3'd3, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h04, 3'd2, 0);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h05, 3'd1, 0);
    addv(0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 0);

    // Reset mid-operation, strobe high across reset, then clear racing a drop
    addPulse(8'h01, 8'h01, 3'd1, 0);
    addPulse(8'h02, 8'h01, 3'd2, 0);
    addPulse(8'h03, 8'h01, 3'd3, 0);
    addPulse(8'h04, 8'h01, 3'd4, 0);
    addPulse(8'h05, 8'h01, 3'd4, 1);
    addv(0, 0, 8'h00, 1, 0, 1, 8'h02, 3'd3, 1);
    addv(1, 1, 8'hAA, 1, 0, 0, 8'h00, 3'd0, 0);
    addv(0, 1, 8'h77, 0, 0, 1, 8'h77, 3'd1, 0);
    addv(0, 0, 8'h00, 0, 0, 1, 8'h77, 3'd1, 0);
    addPulse(8'h81, 8'h77, 3'd2, 0);
    addPulse(8'h82, 8'h77, 3'd3, 0);
    addPulse(8'h83, 8'h77, 3'd4, 0);
    addv(0, 1, 8'hEE, 0, 1, 1, 8'h77, 3'd4, 1);
    addv(0, 0, 8'h00, 0, 1, 1, 8'h77, 3'd4, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Wrap-around: ten captures drained immediately, pointers wrap twice
    v = '{rst:1, cur:0, res:8'h00, rdy:1, clr:0,
          exp_valid:0, exp_data:8'h00, exp_count:3'd0, exp_ovf:0};
    applyStimulus(v);
    checkOutput(v, 1000);
    for (int i = 0; i < 10; i++) begin
      v = '{rst:0, cur:1, res:8'(i), rdy:1, clr:0,
            exp_valid:1, exp_data:8'(i), exp_count:3'd1, exp_ovf:0};
      applyStimulus(v);
      checkOutput(v, 1001 + 2 * i);
      v = '{rst:0, cur:0, res:8'hFF, rdy:1, clr:0,
            exp_valid:0, exp_data:8'h00, exp_count:3'd0, exp_ovf:0};
      applyStimulus(v);
      checkOutput(v, 1002 + 2 * i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
